// File: rtl/gold_catch_if.sv
// Hook-query and gold-position bundle between the claw controller (master) and the catch detector (slave).
// Queries are one-cycle strobes, ignored while busy; results appear as a one-cycle done pulse.
interface gold_catch_if;
    logic [109:0] i_Gold_X;
    logic [99:0]  i_Gold_Y;
    logic         i_Req;
    logic [10:0]  i_Hook_X;
    logic [9:0]   i_Hook_Y;
    logic         i_Clear_Taken;
    logic         o_Busy;
    logic         o_Done;
    logic         o_Hit;
    logic [3:0]   o_Hit_Idx;
    logic [9:0]   o_Taken;
    logic [7:0]   o_Score;

    modport master (
        output i_Gold_X, i_Gold_Y, i_Req, i_Hook_X, i_Hook_Y, i_Clear_Taken,
        input  o_Busy, o_Done, o_Hit, o_Hit_Idx, o_Taken, o_Score
    );

    modport slave (
        input  i_Gold_X, i_Gold_Y, i_Req, i_Hook_X, i_Hook_Y, i_Clear_Taken,
        output o_Busy, o_Done, o_Hit, o_Hit_Idx, o_Taken, o_Score
    );
endinterface

// File: rtl/gold_catch_detector.sv
// Scans ten gold boxes one per clock for the lowest untaken one containing the hook tip; done 2..11 cycles after i_Req.
// Requests arriving while busy are dropped (no queueing); optional score accumulator under macro GOLD_SCORE_EN.
module gold_catch_detector #(
    parameter logic [10:0] GOLD_W     = 11'd40,
    parameter logic [9:0]  GOLD_H     = 10'd40,
    parameter logic [7:0]  GOLD_VALUE = 8'd10
) (
    input  logic         i_Clk,
    input  logic         rst,
    gold_catch_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [10:0] hook_x;
    logic [9:0]  hook_y;
    logic        busy;
    logic        done;
    logic        hit;
    logic [3:0]  hit_idx;
    logic [9:0]  taken;

    logic [10:0] gx;
    logic [9:0]  gy;
    logic        slot_taken;
    logic [9:0]  slot_mask;
    logic        x_ok;
    logic        y_ok;
    logic        hit_now;

    // Select the slot under test from the live position buses.
    always_comb begin
        gx         = '0;
        gy         = '0;
        slot_taken = 1'b0;
        slot_mask  = '0;
        for (int k = 0; k < 10; k++) begin
            if (idx == 4'(k)) begin
                gx           = bus.i_Gold_X[11*k +: 11];
                gy           = bus.i_Gold_Y[10*k +: 10];
                slot_taken   = taken[k];
                slot_mask[k] = 1'b1;
            end
        end
    end

    // One extra bit on the right-edge sums keeps boxes near the screen limit from wrapping.
    always_comb begin
        x_ok    = ({1'b0, hook_x} >= {1'b0, gx}) &&
                  ({1'b0, hook_x} <  ({1'b0, gx} + {1'b0, GOLD_W}));
        y_ok    = ({1'b0, hook_y} >= {1'b0, gy}) &&
                  ({1'b0, hook_y} <  ({1'b0, gy} + {1'b0, GOLD_H}));
        hit_now = x_ok && y_ok && !slot_taken;
    end

    always_ff @(posedge i_Clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            hook_x  <= '0;
            hook_y  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hit     <= 1'b0;
            hit_idx <= '0;
            taken   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_Req) begin
                        state  <= SCAN;
                        busy   <= 1'b1;
                        idx    <= '0;
                        hook_x <= bus.i_Hook_X;
                        hook_y <= bus.i_Hook_Y;
                    end
                end
                SCAN: begin
                    if (hit_now) begin
                        hit     <= 1'b1;
                        hit_idx <= idx;
                        done    <= 1'b1;
                        state   <= REPORT;
                    end else if (idx == 4'd9) begin
                        hit     <= 1'b0;
                        hit_idx <= '0;
                        done    <= 1'b1;
                        state   <= REPORT;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Clear wins over a simultaneous catch; the hit report itself is unaffected.
            if (bus.i_Clear_Taken)
                taken <= '0;
            else if (state == SCAN && hit_now)
                taken <= taken | slot_mask;
        end
    end

    assign bus.o_Busy    = busy;
    assign bus.o_Done    = done;
    assign bus.o_Hit     = hit;
    assign bus.o_Hit_Idx = hit_idx;
    assign bus.o_Taken   = taken;

`ifdef GOLD_SCORE_EN
    logic [7:0] score;
    logic [8:0] score_sum;

    assign score_sum = {1'b0, score} + {1'b0, GOLD_VALUE};

    always_ff @(posedge i_Clk or posedge rst) begin
        if (rst)
            score <= '0;
        else if (state == SCAN && hit_now)
            score <= score_sum[8] ? 8'hFF : score_sum[7:0];
    end

    assign bus.o_Score = score;
`else
    // No score register in this build; output is a constant zero.
    assign bus.o_Score = GOLD_VALUE & 8'h00;
`endif

endmodule

// File: tb/tb_gold_catch_detector.sv
// Directed bench for gold_catch_detector: expected results are queued at request time and checked at o_Done.
module tb_gold_catch_detector;

    logic i_Clk = 1'b0;
    logic rst;

    gold_catch_if bus ();

    gold_catch_detector dut (
        .i_Clk (i_Clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic       hit;
        logic [3:0] idx;
        logic [9:0] taken;
        logic [7:0] score;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [9:0] exp_taken;
    logic [7:0] exp_score;

    always @(negedge i_Clk) if (bus.o_Done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int k, input int x, input int y);
        bus.i_Gold_X[11*k +: 11] = 11'(x);
        bus.i_Gold_Y[10*k +: 10] = 10'(y);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  bus.o_Busy,    0);
        check({tag, "_done"},  bus.o_Done,    0);
        check({tag, "_hit"},   bus.o_Hit,     0);
        check({tag, "_idx"},   bus.o_Hit_Idx, 0);
        check({tag, "_taken"}, bus.o_Taken,   0);
        check({tag, "_score"}, bus.o_Score,   0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_zero(tag);
        @(posedge i_Clk); #1;
        rst = 1'b0;
        exp_taken = '0;
        exp_score = '0;
    endtask

    task automatic pulse_clear();
        bus.i_Clear_Taken = 1'b1;
        @(posedge i_Clk); #1;
        bus.i_Clear_Taken = 1'b0;
        exp_taken = '0;
        check("idle_clear", bus.o_Taken, 0);
    endtask

    // clr_cyc / extra_cyc: cycle number (1 = first scan cycle) at which to drive a clear or a stray request.
    task automatic query(input logic [10:0] hx, input logic [9:0] hy, input logic eh,
                         input logic [3:0] ei, input int clr_cyc, input int extra_cyc);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        if (eh) exp_taken = exp_taken | (10'd1 << ei);
        if (clr_cyc > 0) exp_taken = '0;
`ifdef GOLD_SCORE_EN
        if (eh) exp_score = (exp_score > 8'd245) ? 8'd255 : exp_score + 8'd10;
`endif
        e.hit   = eh;
        e.idx   = eh ? ei : 4'd0;
        e.taken = exp_taken;
        e.score = exp_score;
        e.lat   = eh ? int'(ei) + 2 : 11;
        sb.push_back(e);

        bus.i_Hook_X = hx;
        bus.i_Hook_Y = hy;
        bus.i_Req    = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge i_Clk); #1;
            cyc++;
            bus.i_Req         = (cyc == extra_cyc);
            bus.i_Clear_Taken = (cyc == clr_cyc);
            if (cyc == 1) check("busy_rise", bus.o_Busy, 1);
            if (bus.o_Done === 1'b1) seen = 1'b1;
        end
        bus.i_Req         = 1'b0;
        bus.i_Clear_Taken = 1'b0;

        got = sb.pop_front();
        check("done_seen", seen,          1);
        check("latency",   cyc,           got.lat);
        check("hit",       bus.o_Hit,     got.hit);
        check("hit_idx",   bus.o_Hit_Idx, got.idx);
        check("taken",     bus.o_Taken,   got.taken);
        check("score",     bus.o_Score,   got.score);

        @(posedge i_Clk); #1;
        check("busy_fall", bus.o_Busy,    0);
        check("done_pulse", bus.o_Done,   0);
        check("hit_hold",  bus.o_Hit,     got.hit);
        check("idx_hold",  bus.o_Hit_Idx, got.idx);
    endtask

    initial begin
        int d0;
        rst               = 1'b1;
        bus.i_Req         = 1'b0;
        bus.i_Hook_X      = '0;
        bus.i_Hook_Y      = '0;
        bus.i_Clear_Taken = 1'b0;
        for (int k = 0; k < 10; k++) set_slot(k, 1500, 900);
        exp_taken = '0;
        exp_score = '0;

        #12 check_zero("reset");
        @(posedge i_Clk); #1;
        rst = 1'b0;
        @(posedge i_Clk); #1;

        // Basic catch, repeat on a taken slot, box edges.
        set_slot(3, 640, 334);
        query(11'd650, 10'd350, 1'b1, 4'd3, 0, 0);
        query(11'd650, 10'd350, 1'b0, 4'd0, 0, 0);
        pulse_clear();
        query(11'd680, 10'd350, 1'b0, 4'd0, 0, 0);
        query(11'd640, 10'd334, 1'b1, 4'd3, 0, 0);
        set_slot(5, 2030, 1010);
        query(11'd2040, 10'd1015, 1'b1, 4'd5, 0, 0);

        // Reset in the middle of a scan: everything clears at once and no done follows.
        bus.i_Hook_X = 11'd0;
        bus.i_Hook_Y = 10'd0;
        bus.i_Req    = 1'b1;
        @(posedge i_Clk); #1;
        bus.i_Req = 1'b0;
        repeat (3) begin
            @(posedge i_Clk); #1;
        end
        d0 = done_cnt;
        pulse_reset("midscan_rst");
        repeat (15) begin
            @(posedge i_Clk); #1;
        end
        check("no_done_after_rst", done_cnt, d0);
        query(11'd650, 10'd350, 1'b1, 4'd3, 0, 0);

        // Overlapping boxes: lowest index first, then the next, then nothing.
        set_slot(3, 1500, 900);
        set_slot(5, 1500, 900);
        set_slot(1, 10, 442);
        set_slot(7, 10, 442);
        query(11'd20, 10'd450, 1'b1, 4'd1, 0, 0);
        query(11'd20, 10'd450, 1'b1, 4'd7, 0, 0);
        query(11'd20, 10'd450, 1'b0, 4'd0, 0, 0);

        // Clear coinciding with the hit on slot 0.
        set_slot(0, 100, 100);
        query(11'd110, 10'd110, 1'b1, 4'd0, 1, 0);

        // Stray request while busy must not produce a second done.
        d0 = done_cnt;
        query(11'd0, 10'd0, 1'b0, 4'd0, 0, 5);
        repeat (12) begin
            @(posedge i_Clk); #1;
        end
        check("single_done", done_cnt - d0, 1);

        // Score accumulation from a clean reset: 26 catches.
        pulse_reset("score_rst");
        for (int n = 0; n < 26; n++) begin
            query(11'd110, 10'd110, 1'b1, 4'd0, 0, 0);
            pulse_clear();
        end
`ifdef GOLD_SCORE_EN
        check("score_final", bus.o_Score, 255);
`else
        check("score_final", bus.o_Score, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gold_catch_detector.md
# gold_catch_detector

Consumes the ten gold positions published by the placement logic and answers hook-tip queries. On each request it scans the slots sequentially, one per clock. It reports the lowest-indexed untaken gold whose bounding box contains the hook tip, and marks that gold as taken. It sits between the hook/claw controller (requester) and the VGA renderer (consumer of the taken mask).

## Interface
Parameters:
- GOLD_W, 11'd40: gold box width in pixels.
- GOLD_H, 10'd40: gold box height in pixels.
- GOLD_VALUE, 8'd10: score increment per catch (used only with GOLD_SCORE_EN).

Ports (one clock; reset is asynchronous and active-high):
- i_Clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_Gold_X  in  110  slot k x at [11k+10:11k], k=0..9; top-left corner.
- i_Gold_Y  in  100  slot k y at [10k+9:10k]; top-left corner.
- i_Req  in  1  query strobe; sampled only in IDLE.
- i_Hook_X  in  11  hook tip x; latched with i_Req.
- i_Hook_Y  in  10  hook tip y; latched with i_Req.
- i_Clear_Taken  in  1  synchronous clear of the taken mask (new level).
- o_Busy  out  1  high in SCAN and REPORT.
- o_Done  out  1  one-cycle pulse; result valid.
- o_Hit  out  1  result: catch occurred; held until next o_Done.
- o_Hit_Idx  out  4  caught slot 0..9; held until next o_Done.
- o_Taken  out  10  bit k set once slot k is caught.
- o_Score  out  8  accumulated score.

## Operation
- FSM states: IDLE, SCAN, REPORT.
- IDLE to SCAN: taken when i_Req=1. Latches hook x/y and sets scan index to 0.
- i_Req in SCAN or REPORT: ignored, not queued.
- SCAN: compares slot idx each cycle.
  - Hit test: gx <= hx < gx+GOLD_W and gy <= hy < gy+GOLD_H, and o_Taken[idx]=0.
  - Sums are computed at 12/11 bits, so boxes near the 2047/1023 edge do not wrap.
- Hit in SCAN:
  - Register o_Hit=1 and o_Hit_Idx=idx.
  - Set o_Taken[idx].
  - Go to REPORT; remaining slots are not examined, so the lowest index wins.
- No hit at idx=9: register o_Hit=0 and o_Hit_Idx=0, then go to REPORT.
- REPORT: o_Done=1 for exactly one cycle, then go to IDLE.
- Position buses are read live during SCAN. The upstream block holds them stable after its placement completes.
- i_Clear_Taken:
  - Zeroes o_Taken on the next edge.
  - If it coincides with a hit-set, the clear wins: the mask becomes 0, but o_Hit and o_Hit_Idx still report the catch.
  - Asserted mid-scan, later slots compare against the cleared mask.
- rst, asynchronous, at any time:
  - State returns to IDLE.
  - o_Busy, o_Done, o_Hit: 0.
  - o_Hit_Idx, o_Taken, o_Score: 0.
  - The latched hook position is 0.
  - Any in-flight query is lost, with no o_Done.

## Timing
- Cycle 0: i_Req sampled.
- Cycle k+1: slot k compared.
- Hit on slot k: o_Done high in cycle k+2, so latency is 2 to 11 cycles.
- No hit: o_Done high in cycle 11.
- o_Busy rises the cycle after i_Req and falls with the cycle after o_Done.
- Minimum request spacing: back-to-back i_Req is accepted in the cycle immediately after o_Done.
- o_Taken and o_Score update on the same edge that enters REPORT, so they are visible with o_Done.

## Configuration
- Macro GOLD_SCORE_EN.
- Defined:
  - Each catch adds GOLD_VALUE to o_Score in the cycle o_Hit is set.
  - o_Score saturates at 8'd255.
  - o_Score is cleared only by rst; i_Clear_Taken does not affect it.
- Undefined: o_Score is tied to 8'd0 and no score register is built.

## Test plan
- Reset checks.
  - Assert rst mid-scan (cycle 4) -> all outputs 0 immediately and no o_Done.
  - First i_Req after release is served normally.
- Hit on slot 3.
  - Setup: slot 3 at (640,334), i_Req with hook (650,350).
  - Required: o_Done at cycle 5, o_Hit=1, o_Hit_Idx=3, o_Taken=10'b0000001000.
- Repeat catch and box edges.
  - Repeat the same query -> slot 3 already taken, o_Done at cycle 11, o_Hit=0.
  - Hook (680,350) with GOLD_W=40 -> miss (exclusive right edge).
  - Hook (640,334) -> hit (inclusive corner).
- Overlap.
  - Setup: slots 1 and 7 both at (10,442), hook (20,450).
  - Required: first query gives idx 1; second query gives idx 7; third query misses.
- Clear versus hit.
  - Pulse i_Clear_Taken in the cycle a hit on slot 0 is set.
  - Required: o_Hit=1, o_Hit_Idx=0, o_Taken=0.
  - i_Req pulsed while o_Busy=1 -> no extra o_Done.
- Score (GOLD_SCORE_EN defined).
  - 26 catches with GOLD_VALUE=10 -> o_Score=255 (saturated).
  - Undefined build -> o_Score stays 0 throughout.
